// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared state/owner types and counter width for mem_port_arbiter.
package mem_arb_pkg;
  typedef enum logic {IDLE, WAIT} arb_state_e;
  typedef enum logic {OWN_IF, OWN_LSU} owner_e;
  localparam int CNT_W = 4;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester (IF, LSU) and memory-side signals of the shared port; slave = arbiter side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                if_req;
  logic [ADDR_W-1:0]   if_addr;
  logic                if_gnt;
  logic                if_rvalid;
  logic [DATA_W-1:0]   if_rdata;
  logic                lsu_req;
  logic                lsu_we;
  logic [ADDR_W-1:0]   lsu_addr;
  logic [DATA_W/8-1:0] lsu_bmask;
  logic [DATA_W-1:0]   lsu_wdata;
  logic                lsu_gnt;
  logic                lsu_rvalid;
  logic [DATA_W-1:0]   lsu_rdata;
  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W/8-1:0] mem_bmask;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;
  logic                busy;
  modport slave (
    input  if_req, if_addr, lsu_req, lsu_we, lsu_addr, lsu_bmask, lsu_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, lsu_gnt, lsu_rvalid, lsu_rdata,
           mem_req, mem_we, mem_addr, mem_bmask, mem_wdata, busy
  );
  modport master (
    output if_req, if_addr, lsu_req, lsu_we, lsu_addr, lsu_bmask, lsu_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, lsu_gnt, lsu_rvalid, lsu_rdata,
           mem_req, mem_we, mem_addr, mem_bmask, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter_arb_rr2.sv
// arb_rr2: 2-way arbiter, bit 1 = LSU, bit 0 = IF; round-robin on last grant when ARB_ROUND_ROBIN_EN, else bit 1 wins.
module arb_rr2 (
  input  logic [1:0] req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic       last,
`endif
  output logic [1:0] gnt
);
`ifdef ARB_ROUND_ROBIN_EN
  always_comb gnt = &req ? (last ? 2'b01 : 2'b10) : req;
`else
  always_comb gnt = {req[1], req[0] & ~req[1]};
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between IF and LSU (issue, wait MEM_LAT, respond).
// ARB_ROUND_ROBIN_EN: alternate winner on contention; undefined: LSU always wins.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  arb_state_e state, state_n;
  owner_e owner;
  logic own_we;
  logic [CNT_W-1:0] cnt;
  logic [1:0] pick, gnt;
  logic done;
`ifdef ARB_ROUND_ROBIN_EN
  logic last;
  always_ff @(posedge clk)
    if (rst) last <= 1'b0;
    else if (|gnt) last <= gnt[1];
  arb_rr2 u_arb (.req({bus.lsu_req, bus.if_req}), .last(last), .gnt(pick));
`else
  arb_rr2 u_arb (.req({bus.lsu_req, bus.if_req}), .gnt(pick));
`endif
  // Grants are held off while reset is asserted so every output reads 0 during reset.
  assign gnt  = (state == IDLE && !rst) ? pick : 2'b00;
  assign done = state == WAIT && cnt == '0;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n       = state == IDLE ? (|gnt ? WAIT : IDLE) : (done ? IDLE : WAIT);
    bus.if_gnt    = gnt[0];
    bus.lsu_gnt   = gnt[1];
    bus.mem_req   = |gnt;
    bus.mem_we    = gnt[1] & bus.lsu_we;
    bus.mem_addr  = gnt[1] ? bus.lsu_addr : gnt[0] ? bus.if_addr : {ADDR_W{1'b0}};
    bus.mem_bmask = gnt[1] ? bus.lsu_bmask : '0;
    bus.mem_wdata = gnt[1] ? bus.lsu_wdata : {DATA_W{1'b0}};
    bus.busy      = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      owner          <= OWN_IF;
      own_we         <= 1'b0;
      cnt            <= '0;
      bus.if_rvalid  <= 1'b0;
      bus.lsu_rvalid <= 1'b0;
      bus.if_rdata   <= '0;
      bus.lsu_rdata  <= '0;
    end else begin
      bus.if_rvalid  <= done && owner == OWN_IF;
      bus.lsu_rvalid <= done && owner == OWN_LSU;
      if (|gnt) begin
        owner  <= gnt[1] ? OWN_LSU : OWN_IF;
        own_we <= gnt[1] & bus.lsu_we;
        cnt    <= CNT_W'(MEM_LAT - 1);
      end else if (state == WAIT && !done) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (done && owner == OWN_IF) bus.if_rdata <= bus.mem_rdata;
      if (done && owner == OWN_LSU && !own_we) bus.lsu_rdata <= bus.mem_rdata;
    end
  end
endmodule
